// File: rtl/rvm_iter_unit.sv
// rtl/rvm_iter_unit.sv - iterative RISC-V M-extension multiply/divide unit
// Radix-2 shift-add multiplier and restoring divider sharing one register set.
module rvm_iter_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            kill,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);
  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("rvm_iter_unit: XLEN must be 32 or 64");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t            r_state;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_a;
  logic [XLEN-1:0]   r_b;
  logic [6:0]        r_cnt;
  logic [2:0]        r_op;
  logic              r_word;
  logic              r_neg_q;
  logic              r_neg_r;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
    logic [XLEN-1:0] v;
    v       = {XLEN{x[31]}};
    v[31:0] = x;
    return v;
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] x);
    logic [XLEN-1:0] v;
    v       = '0;
    v[31:0] = x;
    return v;
  endfunction

  logic            w_word, w_is_div, w_a_sgn, w_b_sgn, w_sa, w_sb, w_fast;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min, w_fast_res;

  // Operand conditioning and single-cycle corner cases at accept time
  always_comb begin
    w_word   = (XLEN == 64) && word;
    w_is_div = op[2];
    w_a_sgn  = w_is_div ? ~op[0] : (op[1:0] != 2'b11);
    w_b_sgn  = w_is_div ? ~op[0] : ~op[1];
    w_a_ext  = rs1_data;
    w_b_ext  = rs2_data;
    w_min    = {1'b1, {(XLEN-1){1'b0}}};
    if (w_word) begin
      w_a_ext = w_a_sgn ? sext32(rs1_data[31:0]) : zext32(rs1_data[31:0]);
      w_b_ext = w_b_sgn ? sext32(rs2_data[31:0]) : zext32(rs2_data[31:0]);
      w_min   = ~zext32(32'h7FFF_FFFF);
    end
    w_sa    = w_a_sgn & w_a_ext[XLEN-1];
    w_sb    = w_b_sgn & w_b_ext[XLEN-1];
    w_a_mag = w_sa ? -w_a_ext : w_a_ext;
    w_b_mag = w_sb ? -w_b_ext : w_b_ext;

    w_fast     = 1'b0;
    w_fast_res = '0;
    if (w_is_div && (w_b_ext == '0)) begin
      w_fast     = 1'b1;
      w_fast_res = op[1] ? w_a_ext : '1;
    end else if (w_is_div && !op[0] && (w_a_ext == w_min) && (&w_b_ext)) begin
      w_fast     = 1'b1;
      w_fast_res = op[1] ? '0 : w_a_ext;
    end else if (w_word && !w_is_div && (op[1:0] != 2'b00)) begin
      w_fast = 1'b1;
    end
    if (w_word) w_fast_res = sext32(w_fast_res[31:0]);
  end

  logic [2*XLEN-1:0] w_mul_sum, w_prod;
  logic [XLEN:0]     w_div_t;
  logic [XLEN-1:0]   w_div_diff, w_quo, w_rem, w_fix_res;
  logic              w_div_ge;

  always_comb begin
    w_mul_sum  = r_acc + (r_b[0] ? r_a : '0);
    w_div_t    = {r_acc[XLEN-1:0], r_b[XLEN-1]};
    w_div_ge   = (w_div_t >= {1'b0, r_a[XLEN-1:0]});
    w_div_diff = w_div_t[XLEN-1:0] - r_a[XLEN-1:0];

    w_prod = r_neg_q ? -r_acc : r_acc;
    w_quo  = r_neg_q ? -r_b : r_b;
    w_rem  = r_neg_r ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    if (r_op[2])                 w_fix_res = r_op[1] ? w_rem : w_quo;
    else if (r_op[1:0] == 2'b00) w_fix_res = w_prod[XLEN-1:0];
    else                         w_fix_res = w_prod[2*XLEN-1:XLEN];
    if (r_word) w_fix_res = sext32(w_fix_res[31:0]);
  end

  assign ready = (r_state == S_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      done    <= 1'b0;
      result  <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_word  <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !kill) begin
            r_op    <= op;
            r_word  <= w_word;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_cnt   <= w_word ? 7'd32 : 7'(XLEN);
            r_acc   <= '0;
            if (w_fast) begin
              result  <= w_fast_res;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else if (w_is_div) begin
              // Left-align the dividend so the top of the W-bit field shifts out first
              r_a     <= {{XLEN{1'b0}}, w_b_mag};
              r_b     <= w_word ? (w_a_mag << (XLEN-32)) : w_a_mag;
              r_state <= S_DIV;
            end else begin
              r_a     <= {{XLEN{1'b0}}, w_a_mag};
              r_b     <= w_b_mag;
              r_state <= S_MUL;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (kill) begin
            r_state <= S_IDLE;
          end else begin
            if (r_state == S_MUL) begin
              r_acc <= w_mul_sum;
              r_a   <= r_a << 1;
              r_b   <= r_b >> 1;
            end else begin
              r_acc[XLEN-1:0] <= w_div_ge ? w_div_diff : w_div_t[XLEN-1:0];
              r_b             <= {r_b[XLEN-2:0], w_div_ge};
            end
            r_cnt <= r_cnt - 7'd1;
            if (r_cnt == 7'd1) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          if (!kill) begin
            result  <= w_fix_res;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rvm_iter_unit.sv
// tb/tb_rvm_iter_unit.sv - self-checking bench for rvm_iter_unit at XLEN 32 and 64
module tb_rvm_iter_unit;
  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, start32, start64, word, kill;
  logic [2:0]  op;
  logic [63:0] rs1, rs2;
  logic        rdy32, done32, rdy64, done64;
  logic [31:0] res32;
  logic [63:0] res64;
  int          ntests = 0;
  int          nfail  = 0;

  rvm_iter_unit #(.XLEN(32)) u32 (
    .CLK(CLK), .RST(RST), .start(start32), .op(op), .word(word),
    .rs1_data(rs1[31:0]), .rs2_data(rs2[31:0]), .kill(kill),
    .ready(rdy32), .done(done32), .result(res32)
  );

  rvm_iter_unit #(.XLEN(64)) u64 (
    .CLK(CLK), .RST(RST), .start(start64), .op(op), .word(word),
    .rs1_data(rs1), .rs2_data(rs2), .kill(kill),
    .ready(rdy64), .done(done64), .result(res64)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural reference: exact integer arithmetic on wide signed values
  function automatic logic [63:0] model(input int xl, input logic [2:0] o, input logic wd,
                                        input logic [63:0] a, input logic [63:0] b);
    int                 w;
    bit                 sa, sb;
    logic signed [129:0] x, y, r;
    logic [63:0]        v;
    w  = (wd && xl == 64) ? 32 : xl;
    sa = (o == 3'd0 || o == 3'd1 || o == 3'd2 || o == 3'd4 || o == 3'd6);
    sb = (o == 3'd0 || o == 3'd1 || o == 3'd4 || o == 3'd6);
    if (w == 64) begin
      x = sa ? {{66{a[63]}}, a} : {66'b0, a};
      y = sb ? {{66{b[63]}}, b} : {66'b0, b};
    end else begin
      x = sa ? {{98{a[31]}}, a[31:0]} : {98'b0, a[31:0]};
      y = sb ? {{98{b[31]}}, b[31:0]} : {98'b0, b[31:0]};
    end
    if (w == 32 && xl == 64 && o != 3'd0 && !o[2]) r = 0;
    else begin
      case (o)
        3'd0:             r = x * y;
        3'd1, 3'd2, 3'd3: r = (x * y) >>> w;
        3'd4, 3'd5:       r = (y == 0) ? -1 : x / y;
        default:          r = (y == 0) ? x : x % y;
      endcase
    end
    v = r[63:0];
    if (w == 32) v[63:32] = (xl == 64) ? {32{v[31]}} : 32'b0;
    return v;
  endfunction

  function automatic int lat(input int xl, input logic [2:0] o, input logic wd,
                             input logic [63:0] a, input logic [63:0] b);
    int          w;
    logic [63:0] am, bm, ones;
    w    = (wd && xl == 64) ? 32 : xl;
    am   = (w == 32) ? {32'b0, a[31:0]} : a;
    bm   = (w == 32) ? {32'b0, b[31:0]} : b;
    ones = (w == 32) ? 64'hFFFF_FFFF : '1;
    if (o[2]) begin
      if (bm == 0) return 1;
      if (!o[0] && bm == ones && am == (64'h1 << (w - 1))) return 1;
    end else if (w == 32 && xl == 64 && o != 3'd0) begin
      return 1;
    end
    return w + 2;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0:       return 64'h0;
      1:       return 64'h1;
      2:       return '1;
      3:       return 64'h8000_0000_0000_0000;
      4:       return 64'h0000_0000_8000_0000;
      5:       return {32'h0, $urandom_range(0, 20)};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic o_done(input bit is64);
    return is64 ? done64 : done32;
  endfunction
  function automatic logic o_rdy(input bit is64);
    return is64 ? rdy64 : rdy32;
  endfunction
  function automatic logic [63:0] o_res(input bit is64);
    return is64 ? res64 : {32'b0, res32};
  endfunction

  task automatic run_op(input string tag, input bit is64, input logic [2:0] o, input logic wd,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    int xl  = is64 ? 64 : 32;
    int el  = lat(xl, o, wd, a, b);
    int got = -1;
    op = o; word = wd; rs1 = a; rs2 = b;
    if (is64) start64 = 1'b1; else start32 = 1'b1;
    step();
    start32 = 1'b0; start64 = 1'b0;
    check({tag, "_busy"}, 64'(o_rdy(is64)), 64'd0);
    for (int c = 1; c <= 80; c++) begin
      if (o_done(is64)) begin got = c; break; end
      step();
    end
    check({tag, "_done_cycle"}, 64'(got), 64'(el));
    check({tag, "_result"}, o_res(is64), exp);
    step();
    check({tag, "_ready_after"}, 64'(o_rdy(is64)), 64'd1);
  endtask

  initial begin
    int          got, cyc;
    bit          seen;
    logic [2:0]  ro;
    logic        rw;
    logic [63:0] ra, rb;

    RST = 1'b1; start32 = 1'b0; start64 = 1'b0; kill = 1'b0;
    op = 3'd0; word = 1'b0; rs1 = '0; rs2 = '0;
    step(); step();
    RST = 1'b0;
    check("reset_ready32", 64'(rdy32), 64'd1);
    check("reset_done32", 64'(done32), 64'd0);
    check("reset_result32", {32'b0, res32}, 64'd0);
    check("reset_ready64", 64'(rdy64), 64'd1);
    check("reset_result64", res64, 64'd0);

    run_op("mul_neg3", 0, 3'd0, 0, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB);
    run_op("mulhu_ones", 0, 3'd3, 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE);
    run_op("mulh_ones", 0, 3'd1, 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0);
    run_op("mulhsu", 0, 3'd2, 0, 64'hFFFF_FFFF, 64'd2, 64'hFFFF_FFFF);
    run_op("div_by0", 0, 3'd4, 0, 64'd5, 64'd0, 64'hFFFF_FFFF);
    run_op("rem_by0", 0, 3'd6, 0, 64'd5, 64'd0, 64'd5);
    run_op("div_ovf", 0, 3'd4, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000);
    run_op("rem_ovf", 0, 3'd6, 0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0);
    run_op("rem_neg7", 0, 3'd6, 0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF);

    run_op("divw_neg7", 1, 3'd4, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("mulw_sext", 1, 3'd0, 1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("mulhu64", 1, 3'd3, 0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("divw_ovf", 1, 3'd4, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    run_op("mulhw_bad", 1, 3'd1, 1, 64'h1234, 64'h5678, 64'h0);
    run_op("remuw_by0", 1, 3'd7, 1, 64'hDEAD_BEEF_8000_0001, 64'h0, 64'hFFFF_FFFF_8000_0001);

    // kill in cycle 10 of a DIVU
    op = 3'd5; word = 1'b0; rs1 = 64'd1000; rs2 = 64'd7; start32 = 1'b1;
    step();
    start32 = 1'b0;
    seen = 1'b0;
    for (int c = 1; c < 10; c++) begin
      seen |= done32;
      step();
    end
    kill = 1'b1;
    step();
    kill = 1'b0;
    check("kill_no_done", 64'(seen | done32), 64'd0);
    check("kill_ready", 64'(rdy32), 64'd1);
    check("kill_result_held", {32'b0, res32}, 64'hFFFF_FFFF);
    run_op("after_kill", 0, 3'd5, 0, 64'd1000, 64'd7, 64'd142);

    // start while busy and start in the done cycle are both ignored
    op = 3'd0; rs1 = 64'h1234; rs2 = 64'h10; start32 = 1'b1;
    step();
    start32 = 1'b0; cyc = 1;
    repeat (3) begin step(); cyc++; end
    op = 3'd4; rs1 = 64'd9; rs2 = 64'd3; start32 = 1'b1;
    step();
    start32 = 1'b0; cyc++;
    got = -1;
    for (int c = 0; c < 60; c++) begin
      if (done32) begin got = cyc; break; end
      step(); cyc++;
    end
    check("busy_done_cycle", 64'(got), 64'd34);
    check("busy_result", {32'b0, res32}, 64'h12340);
    op = 3'd0; rs1 = 64'd2; rs2 = 64'd3; start32 = 1'b1;
    step();
    start32 = 1'b0;
    check("done_cycle_start_ignored", 64'(rdy32), 64'd1);
    check("done_cycle_result_held", {32'b0, res32}, 64'h12340);

    // reset in the middle of a multiply
    op = 3'd0; rs1 = 64'd5; rs2 = 64'd5; start32 = 1'b1;
    step();
    start32 = 1'b0;
    repeat (5) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rst_mid_done", 64'(done32), 64'd0);
    check("rst_mid_result", {32'b0, res32}, 64'd0);
    check("rst_mid_ready", 64'(rdy32), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      seen |= done32;
      step();
    end
    check("rst_mid_no_late_done", 64'(seen), 64'd0);

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7)); rw = 1'($urandom_range(0, 1));
      ra = pick(); rb = pick();
      run_op("rand32", 0, ro, rw, ra, rb, model(32, ro, rw, ra, rb));
      ro = 3'($urandom_range(0, 7)); rw = 1'($urandom_range(0, 1));
      ra = pick(); rb = pick();
      run_op("rand64", 1, ro, rw, ra, rb, model(64, ro, rw, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/rvm_iter_unit.md
Name: rvm_iter_unit

Overview:
Iterative multiply/divide functional unit implementing the full M extension for a parametrised XLEN (32 or 64). For XLEN=64 it also implements the RV64M word variants. It sits in the execute stage beside the ALU. Decode drives it with the 3-bit M funct3 operation code plus a word flag, and it returns a registered result with a start/done handshake. The unit uses a radix-2 shift-add multiplier and a restoring divider sharing one datapath, with single-cycle fast paths for the architectural divide corner cases.

Parameters:
XLEN, 32, datapath width; legal values 32 and 64; any other value is an elaboration error.

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous reset, active-high
start  input  1  request; accepted only when ready=1
op  input  3  M-op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
word  input  1  RV64 W-variant select; ignored (treated 0) when XLEN=32
rs1_data  input  XLEN  operand A (multiplicand/dividend)
rs2_data  input  XLEN  operand B (multiplier/divisor)
kill  input  1  abort in-flight operation (pipeline flush)
ready  output  1  unit idle, can accept start
done  output  1  one-cycle pulse, result valid
result  output  XLEN  result, held stable from done until next accepted start

Behaviour:
- Reset (RST=1 at edge): state IDLE, done=0, result=0, internal registers cleared; ready=1 from the first cycle after reset. A reset mid-operation aborts with no done.
- ready = (state==IDLE). start with ready=0 is ignored; it is not queued.
- States: IDLE, MUL, DIV, FIX, DONE.
  - IDLE -start(mul op)-> MUL
  - IDLE -start(div op, normal)-> DIV
  - IDLE -start(div fast path)-> DONE
  - MUL/DIV -last iteration-> FIX -> DONE -> IDLE
- Accept cycle is cycle 0. Operands are latched and converted to magnitudes per signedness:
  - MUL/MULH/DIV/REM: both signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Effective width W = 32 when word=1 (operands are the low 32 bits, sign/zero extended from bit 31 per op), else XLEN.
- Iterations occupy cycles 1..W, one bit per cycle. FIX occupies cycle W+1 and applies the sign correction and half selection. done=1 and result is valid in cycle W+2. The unit returns to IDLE (ready=1) in cycle W+3, so back-to-back throughput is one op per W+3 cycles.
- Multiply: 2W-bit product.
  - MUL returns bits [W-1:0].
  - MULH/MULHSU/MULHU return bits [2W-1:W].
  - The product is negated when the operand signs differ (signed operands only).
- Divide: truncating toward zero. Quotient sign = signA xor signB; remainder sign = dividend sign.
- Fast path (state DONE directly, done in cycle 1, result computed at W width):
  - Divisor==0: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Signed overflow (dividend=most-negative at W, divisor=-1, DIV/REM): DIV returns the dividend, REM returns 0.
  - word=1 with op in {MULH, MULHSU, MULHU} (not an instruction): result 0. Decode never issues this combination.
- word=1: the W=32 result is sign-extended from bit 31 to XLEN, including fast-path results.
- kill: while the state is not IDLE, the next state is IDLE, with no done and result unchanged. kill in the same cycle as start while IDLE means the start is ignored. kill in the DONE cycle still lets done assert that cycle; the pipeline discards it.
- start asserted in the same cycle as done is ignored, because ready=0.

Test Plan:
- XLEN=32, MUL 7 x 0xFFFFFFFD (-3) -> done in cycle 34, result 0xFFFFFFEB; ready back in cycle 35.
- XLEN=32, MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH on the same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- XLEN=32, DIV 5/0 -> 0xFFFFFFFF with done in cycle 1. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same -> 0. REM -7/2 -> 0xFFFFFFFF (-1).
- XLEN=64, DIVW rs1=0x00000000_FFFFFFF9 (-7 as word), rs2=2 -> 0xFFFFFFFF_FFFFFFFD (-3), done in cycle 34. MULW 0x7FFFFFFF x 2 -> 0xFFFFFFFF_FFFFFFFE.
- kill asserted in cycle 10 of a 32-bit DIVU -> no done pulse, ready=1 in cycle 11, and a start in cycle 11 completes correctly.
- RST asserted mid-MUL -> done=0, result=0, ready=1 the cycle after reset deasserts. start while busy is ignored, and the original result is unaffected.
